uart_rx: RTL and testbench

Asynchronous serial receiver: oversamples a raw RX line, frames 8N1-style characters (start, `Databits` data LSB-first, one stop), and presents each completed word on a valid/ready output register. Sits directly upstream of the bus-side deserialised-data path. It produces the per-bit shift strobe and sampled bit internally and hands whole words to the UART peripheral's register/FIFO logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_vote.sv | 35 +++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state type, default
// bit timing and the 2-of-3 majority helper used by the sample voter.
package uart_pkg;

    localparam int unsigned UART_DEFAULT_BITCLKS  = 868;
    localparam int unsigned UART_DEFAULT_DATABITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// RX line synchroniser plus 3-sample majority voter. The vote is valid on the
// cycle the caller's bit counter reads 0: it covers that cycle and the two before.
module uart_rx_vote
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic synced,
    output logic voted,
    output logic fall
);

    logic       meta_q;
    logic       sync_q;
    logic [1:0] hist_q;

    // All stages reset to the idle (high) level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 2'b11;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            hist_q <= {hist_q[0], sync_q};
        end
    end

    assign synced = sync_q;
    assign voted  = majority3(sync_q, hist_q[0], hist_q[1]);
    assign fall   = hist_q[0] & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frames start/data/stop from the voted RX line and presents each
// word on a valid/ready output register with frame-error and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned Bitclks  = UART_DEFAULT_BITCLKS,
    parameter int unsigned Databits = UART_DEFAULT_DATABITS
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                RX,
    output logic [Databits-1:0] DATA,
    output logic                VALID,
    input  logic                READY,
    output logic                FRAMEERR,
    output logic                OVERRUN,
    input  logic                ERRCLR
);

    localparam int unsigned CntW = $clog2(Bitclks);
    localparam int unsigned IdxW = $clog2(Databits + 1);

    localparam logic [CntW-1:0] HalfLoad = CntW'(Bitclks / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(Bitclks - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(Databits - 1);

    logic synced;
    logic voted;
    logic fall;

    uart_rx_state_t      state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [Databits-1:0] shift_q, shift_d;
    logic [Databits-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                frameerr_q, frameerr_d;
    logic                overrun_q, overrun_d;

    logic cnt_zero;
    logic word_done;

    uart_rx_vote u_vote (
        .clk    (CLK),
        .rst_n  (nRST),
        .rx     (RX),
        .synced (synced),
        .voted  (voted),
        .fall   (fall)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        frameerr_d = 1'b0;
        word_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    cnt_d   = HalfLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (voted) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = FullLoad;
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {voted, shift_q[Databits-1:1]};
                    cnt_d   = FullLoad;
                    if (idx_q == LastIdx) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (voted) begin
                    word_done = 1'b1;
                    state_d   = StIdle;
                end else begin
                    frameerr_d = 1'b1;
                    state_d    = StBreak;
                end
            end
            StBreak: begin
                if (synced) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A word is taken only into a free register (or one being drained this cycle);
    // otherwise it is dropped and the overrun flag latches.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && READY) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || READY) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (ERRCLR) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frameerr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            frameerr_q <= frameerr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign DATA     = data_q;
    assign VALID    = valid_q;
    assign FRAMEERR = frameerr_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized checks of uart_rx at 16 clocks per bit against a
// queue-based model of the words and frame errors the line should produce.
module tb_uart_rx;

    localparam int unsigned Bitclks     = 16;
    localparam int unsigned Databits    = 8;
    localparam int          FrameCycles = 10 * Bitclks;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       RX = 1'b1;
    logic       READY = 1'b0;
    logic       ERRCLR = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAMEERR;
    logic       OVERRUN;

    uart_rx #(
        .Bitclks  (Bitclks),
        .Databits (Databits)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .RX       (RX),
        .DATA     (DATA),
        .VALID    (VALID),
        .READY    (READY),
        .FRAMEERR (FRAMEERR),
        .OVERRUN  (OVERRUN),
        .ERRCLR   (ERRCLR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    int         n_fe = 0;
    int         n_vhi = 0;

    // Observer: accepted words, frame-error pulse cycles, VALID-high cycles.
    always @(negedge CLK) begin
        if (nRST) begin
            if (VALID && READY) got_q.push_back(DATA);
            if (FRAMEERR) n_fe++;
            if (VALID) n_vhi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drives ncyc cycles of a frame; cycle index glitch (if >= 0) is inverted.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch,
                              input int ncyc);
        int   b;
        logic lvl;
        for (int c = 0; c < ncyc; c++) begin
            b = c / Bitclks;
            if (b == 0) lvl = 1'b0;
            else if (b <= 8) lvl = d[b-1];
            else lvl = stop;
            if (c == glitch) lvl = ~lvl;
            RX = lvl;
            cyc(1);
        end
    endtask

    initial begin
        int         base_hs;
        int         base_v;
        int         base_fe;
        int         exp_fe;
        logic [7:0] exp_q[$];
        logic [7:0] rnd;
        logic       stp;
        logic [31:0] obs;

        // Reset state
        cyc(3);
        check("rst_data", 32'(DATA), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_frameerr", 32'(FRAMEERR), 32'h0);
        check("rst_overrun", 32'(OVERRUN), 32'h0);
        nRST = 1'b1;
        cyc(5);

        // Clean 0xA5 frame with consumer always ready
        READY   = 1'b1;
        base_hs = got_q.size();
        base_v  = n_vhi;
        base_fe = n_fe;
        send_frame(8'hA5, 1'b1, -1, FrameCycles);
        RX = 1'b1;
        cyc(10);
        check("a5_count", got_q.size(), base_hs + 1);
        check("a5_data", 32'(got_q[$]), 32'hA5);
        check("a5_valid_cycles", n_vhi - base_v, 1);
        check("a5_no_frameerr", n_fe - base_fe, 0);
        check("a5_no_overrun", 32'(OVERRUN), 32'h0);

        // False start: 4 low cycles
        base_hs = got_q.size();
        base_v  = n_vhi;
        RX = 1'b0;
        cyc(4);
        RX = 1'b1;
        cyc(40);
        check("false_no_word", got_q.size(), base_hs);
        check("false_no_valid", n_vhi - base_v, 0);
        check("false_no_frameerr", n_fe - base_fe, 0);

        // Single-cycle glitch in the middle of bit 3 of 0x00
        base_hs = got_q.size();
        send_frame(8'h00, 1'b1, 4 * Bitclks + Bitclks / 2, FrameCycles);
        RX = 1'b1;
        cyc(10);
        check("glitch_count", got_q.size(), base_hs + 1);
        check("glitch_data", 32'(got_q[$]), 32'h00);

        // 0x3C with a low stop bit, line held in break, then 0x81
        base_hs = got_q.size();
        base_v  = n_vhi;
        send_frame(8'h3C, 1'b0, -1, FrameCycles);
        RX = 1'b0;
        cyc(30);
        check("ferr_pulse", n_fe - base_fe, 1);
        check("ferr_no_valid", n_vhi - base_v, 0);
        RX = 1'b1;
        cyc(5);
        send_frame(8'h81, 1'b1, -1, FrameCycles);
        RX = 1'b1;
        cyc(10);
        check("after_break_count", got_q.size(), base_hs + 1);
        check("after_break_data", 32'(got_q[$]), 32'h81);
        check("after_break_fe", n_fe - base_fe, 1);

        // Overrun: two words back to back with nobody consuming
        READY = 1'b0;
        send_frame(8'h11, 1'b1, -1, FrameCycles);
        send_frame(8'h22, 1'b1, -1, FrameCycles);
        RX = 1'b1;
        cyc(10);
        check("ovr_valid", 32'(VALID), 32'h1);
        check("ovr_data", 32'(DATA), 32'h11);
        check("ovr_flag", 32'(OVERRUN), 32'h1);
        READY = 1'b1;
        cyc(1);
        check("ovr_drain_valid", 32'(VALID), 32'h0);
        check("ovr_sticky", 32'(OVERRUN), 32'h1);
        check("ovr_drained_word", 32'(got_q[$]), 32'h11);
        READY  = 1'b0;
        ERRCLR = 1'b1;
        cyc(1);
        ERRCLR = 1'b0;
        check("ovr_clear", 32'(OVERRUN), 32'h0);

        // Reset in the middle of bit 4 with a pending word and overrun set
        send_frame(8'h33, 1'b1, -1, FrameCycles);
        send_frame(8'h44, 1'b1, -1, FrameCycles);
        RX = 1'b1;
        cyc(10);
        check("pre_rst_valid", 32'(VALID), 32'h1);
        check("pre_rst_data", 32'(DATA), 32'h33);
        check("pre_rst_overrun", 32'(OVERRUN), 32'h1);
        send_frame(8'h99, 1'b1, -1, 5 * Bitclks + Bitclks / 2);
        #2;
        nRST = 1'b0;
        #1;
        check("midrst_data", 32'(DATA), 32'h0);
        check("midrst_valid", 32'(VALID), 32'h0);
        check("midrst_overrun", 32'(OVERRUN), 32'h0);
        check("midrst_frameerr", 32'(FRAMEERR), 32'h0);
        RX = 1'b1;
        cyc(2);
        nRST = 1'b1;
        cyc(20);
        check("postrst_idle_valid", 32'(VALID), 32'h0);
        READY   = 1'b1;
        base_hs = got_q.size();
        base_fe = n_fe;
        send_frame(8'h5A, 1'b1, -1, FrameCycles);
        RX = 1'b1;
        cyc(10);
        check("postrst_count", got_q.size(), base_hs + 1);
        check("postrst_data", 32'(got_q[$]), 32'h5A);
        check("postrst_fe", n_fe - base_fe, 0);

        // Randomized frames: random data, occasional bad stop, 0..2 idle gap
        base_hs = got_q.size();
        base_v  = n_vhi;
        base_fe = n_fe;
        exp_fe  = 0;
        for (int i = 0; i < 12; i++) begin
            rnd = 8'($urandom);
            stp = ($urandom_range(3) != 0);
            send_frame(rnd, stp, -1, FrameCycles);
            RX = 1'b1;
            if (stp) begin
                exp_q.push_back(rnd);
                cyc(int'($urandom_range(2)));
            end else begin
                exp_fe++;
                cyc(20);
            end
        end
        cyc(10);
        check("rand_count", got_q.size() - base_hs, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (base_hs + i < got_q.size()) ? 32'(got_q[base_hs + i]) : 32'hFFFF_FFFF;
            check($sformatf("rand_word%0d", i), obs, 32'(exp_q[i]));
        end
        check("rand_frameerr", n_fe - base_fe, exp_fe);
        check("rand_valid_cycles", n_vhi - base_v, exp_q.size());
        check("rand_no_overrun", 32'(OVERRUN), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
